// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared link-scheduler state encoding and timing constants
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TX      = 2'd1,
    ST_RX_HOLD = 2'd2,
    ST_GUARD   = 2'd3
  } link_state_t;

  localparam int DEF_FRAME_BITS = 12;
  localparam int DEF_GUARD_BITS = 2;

  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// rtl/uart_rr_arbiter.sv - combinational round-robin pick starting one past ptr
module uart_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_win,
  output logic [PW-1:0]   o_win_idx
);

  logic          w_found;
  logic [PW-1:0] w_cand;

  always_comb begin
    o_win     = '0;
    o_win_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = PW'((int'(i_ptr) + k) % NREQ);
      if (!w_found && i_req[w_cand]) begin
        o_win[w_cand] = 1'b1;
        o_win_idx     = w_cand;
        w_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_link_sched.sv
// rtl/uart_link_sched.sv - half-duplex scheduler sharing one UART transmitter among NREQ requesters
module uart_link_sched
  import uart_ctrl_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int Baud       = 9600,
  parameter int DataBits   = 8,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int GUARD_BITS = DEF_GUARD_BITS,
  parameter int NREQ       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DataBits-1:0] data_in,
  input  logic                     rx_line,
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          done,
  output logic                     uart_en,
  output logic [DataBits-1:0]      uart_data,
  output logic                     busy
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, Baud);
  localparam int FRAME_CYC  = FRAME_BITS * BIT_CYCLES;
  localparam int GUARD_CYC  = GUARD_BITS * BIT_CYCLES;
  localparam int MAX_CYC    = (FRAME_CYC > GUARD_CYC) ? FRAME_CYC : GUARD_CYC;
  localparam int CW         = $clog2(MAX_CYC + 1);
  localparam int PW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] FRAME_LD = CW'(FRAME_CYC);
  localparam logic [CW-1:0] GUARD_LD = CW'(GUARD_CYC);

  link_state_t         r_state, w_state_nxt;
  logic [1:0]          r_sync;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [PW-1:0]       r_ptr, w_ptr_nxt;
  logic [NREQ-1:0]     r_owner, w_owner_nxt;
  logic [NREQ-1:0]     r_grant, w_grant_nxt;
  logic [NREQ-1:0]     r_done, w_done_nxt;
  logic [DataBits-1:0] r_uart_data, w_data_nxt;
  logic                r_uart_en, r_busy;

  logic                w_rx_s;
  logic [NREQ-1:0]     w_win;
  logic [PW-1:0]       w_win_idx;
  logic [DataBits-1:0] w_slot [NREQ];

  assign w_rx_s = r_sync[1];

  uart_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .o_win     (w_win),
    .o_win_idx (w_win_idx)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) w_slot[i] = data_in[i*DataBits +: DataBits];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_grant_nxt = '0;
    w_done_nxt  = '0;
    w_data_nxt  = r_uart_data;
    case (r_state)
      ST_IDLE: begin
        // The far end starting a frame beats any pending local request.
        if (!w_rx_s) begin
          w_state_nxt = ST_RX_HOLD;
          w_cnt_nxt   = FRAME_LD;
        end else if (|req) begin
          w_state_nxt = ST_TX;
          w_cnt_nxt   = FRAME_LD;
          w_grant_nxt = w_win;
          w_owner_nxt = w_win;
          w_ptr_nxt   = w_win_idx;
          w_data_nxt  = w_slot[w_win_idx];
        end
      end
      ST_TX: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt = ST_GUARD;
          w_cnt_nxt   = GUARD_LD;
          w_done_nxt  = r_owner;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_RX_HOLD: begin
        if (r_cnt == '0 && w_rx_s) begin
          w_state_nxt = ST_GUARD;
          w_cnt_nxt   = GUARD_LD;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_GUARD: begin
        if (!w_rx_s) begin
          w_state_nxt = ST_RX_HOLD;
          w_cnt_nxt   = FRAME_LD;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= 2'b11;
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ptr       <= PW'(NREQ - 1);
      r_owner     <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_uart_data <= '0;
      r_uart_en   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], rx_line};
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ptr       <= w_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_grant     <= w_grant_nxt;
      r_done      <= w_done_nxt;
      r_uart_data <= w_data_nxt;
      r_uart_en   <= (w_state_nxt == ST_TX);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign grant     = r_grant;
  assign done      = r_done;
  assign uart_en   = r_uart_en;
  assign uart_data = r_uart_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_link_sched.sv
// tb/tb_uart_link_sched.sv - directed bench: 48-cycle frame, 8-cycle guard, four requesters
module tb_uart_link_sched;

  localparam int NREQ  = 4;
  localparam int DB    = 8;
  localparam int FRAME = 48;
  localparam int GAP   = 57;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DB-1:0] data_in = '0;
  logic              rx_line = 1'b1;
  logic [NREQ-1:0]   grant, done;
  logic              uart_en, busy;
  logic [DB-1:0]     uart_data;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_grant;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tv [12];

  uart_link_sched #(
    .CLK_FREQ(4), .Baud(1), .DataBits(DB), .FRAME_BITS(12), .GUARD_BITS(2), .NREQ(NREQ)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .rx_line(rx_line),
    .grant(grant), .done(done), .uart_en(uart_en), .uart_data(uart_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int limit);
    int n = 0;
    while (grant == '0 && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      step();
      n++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic frame_to_done(input string name, input logic [3:0] exp_done);
    int n = 0;
    while (uart_en && n < 100) begin
      n++;
      step();
    end
    check({name, "_en_len"}, n, FRAME);
    check({name, "_done"}, done, exp_done);
  endtask

  initial begin
    int last_g, c0, d0, ent;
    logic [3:0] seen;

    tv[0]  = '{4'b0001, 4'b0001, 8'hA5};
    tv[1]  = '{4'b1111, 4'b0010, 8'h5A};
    tv[2]  = '{4'b1111, 4'b0100, 8'h96};
    tv[3]  = '{4'b1111, 4'b1000, 8'h3C};
    tv[4]  = '{4'b1111, 4'b0001, 8'hA5};
    tv[5]  = '{4'b1001, 4'b1000, 8'h3C};
    tv[6]  = '{4'b1001, 4'b0001, 8'hA5};
    tv[7]  = '{4'b0100, 4'b0100, 8'h96};
    tv[8]  = '{4'b0011, 4'b0001, 8'hA5};
    tv[9]  = '{4'b0011, 4'b0010, 8'h5A};
    tv[10] = '{4'b1100, 4'b0100, 8'h96};
    tv[11] = '{4'b1010, 4'b1000, 8'h3C};

    data_in = {8'h3C, 8'h96, 8'h5A, 8'hA5};
    repeat (3) step();
    check("rst_grant", grant, 4'b0);
    check("rst_done", done, 4'b0);
    check("rst_en", uart_en, 1'b0);
    check("rst_data", uart_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();
    check("idle_busy", busy, 1'b0);

    last_g = 0;
    for (int i = 0; i < 12; i++) begin
      req = tv[i].req;
      wait_grant(200);
      check($sformatf("v%0d_grant", i), grant, tv[i].exp_grant);
      check($sformatf("v%0d_data", i), uart_data, tv[i].exp_data);
      check($sformatf("v%0d_en", i), uart_en, 1'b1);
      check($sformatf("v%0d_busy", i), busy, 1'b1);
      if (i > 0) check($sformatf("v%0d_gap", i), cyc - last_g, GAP);
      last_g = cyc;
      req = '0;
      frame_to_done($sformatf("v%0d", i), tv[i].exp_grant);
    end

    // Receive wins over a request seen in the same IDLE cycle.
    wait_idle(50);
    c0 = cyc;
    rx_line = 1'b0;
    step();
    step();
    check("rx_sync_busy", busy, 1'b0);
    req = 4'b0010;
    step();
    check("rx_entry_busy", busy, 1'b1);
    check("rx_entry_grant", grant, 4'b0);
    check("rx_entry_en", uart_en, 1'b0);
    check("rx_entry_lat", cyc - c0, 3);
    ent = cyc;
    repeat (8) step();
    rx_line = 1'b1;
    wait_grant(200);
    check("rx_grant_lat", cyc - ent, 58);
    check("rx_grant", grant, 4'b0010);
    check("rx_data", uart_data, 8'h5A);
    req = '0;
    frame_to_done("rx", 4'b0010);

    // One-cycle low pulse landing on guard cycle 3 restarts a full receive hold.
    d0 = cyc;
    rx_line = 1'b0;
    req = 4'b0100;
    step();
    rx_line = 1'b1;
    step();
    step();
    check("grx_busy", busy, 1'b1);
    check("grx_en", uart_en, 1'b0);
    wait_grant(200);
    check("grx_grant_lat", cyc - d0, 61);
    check("grx_grant", grant, 4'b0100);
    check("grx_data", uart_data, 8'h96);
    req = '0;
    frame_to_done("grx", 4'b0100);

    // Long break: hold persists until the line returns high.
    wait_idle(50);
    c0 = cyc;
    rx_line = 1'b0;
    seen = '0;
    repeat (3) step();
    check("brk_busy", busy, 1'b1);
    req = 4'b1000;
    while (cyc - c0 < 100) begin
      step();
      seen = seen | grant;
    end
    rx_line = 1'b1;
    while (busy && cyc - c0 < 300) begin
      step();
      seen = seen | grant;
    end
    check("brk_no_grant", seen, 4'b0);
    check("brk_idle_at", cyc - c0, 111);
    step();
    check("brk_grant", grant, 4'b1000);
    check("brk_data", uart_data, 8'h3C);
    req = '0;
    frame_to_done("brk", 4'b1000);

    // Reset in the middle of a frame, then restart at requester 0.
    wait_idle(50);
    req = 4'b0100;
    wait_grant(20);
    check("mid_grant", grant, 4'b0100);
    req = '0;
    repeat (20) step();
    check("mid_en", uart_en, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mrst_en", uart_en, 1'b0);
    check("mrst_grant", grant, 4'b0);
    check("mrst_done", done, 4'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_data", uart_data, 8'h00);
    req = 4'b1111;
    step();
    step();
    rst_n = 1'b1;
    wait_grant(20);
    check("post_rst_grant", grant, 4'b0001);
    check("post_rst_data", uart_data, 8'hA5);
    check("post_rst_en", uart_en, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
